// File: rtl/vga_timing_gen_v2.sv
// Parametrised VGA/LCD raster timing generator with pixel enable, sync/DE delay line and frame strobes.
// Optional RGB pass-through with blanking is enabled by defining VGA_RGB_PASS_EN.
module vga_timing_gen_v2 #(
  parameter int unsigned H_DISP   = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_PULSE  = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_DISP   = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_PULSE  = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CNT_W    = 10,
  parameter int unsigned HS_POL   = 0,
  parameter int unsigned VS_POL   = 0,
  parameter int unsigned PIPE_DLY = 2
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_en,
`ifdef VGA_RGB_PASS_EN
  input  logic [23:0]      i_rgb,
  output logic [23:0]      o_rgb,
`endif
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output logic             o_active,
  output logic             o_de,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_sof,
  output logic             o_eol,
  output logic [15:0]      o_frame_cnt
);

  localparam int unsigned H_TOTAL  = H_DISP + H_FP + H_PULSE + H_BP;
  localparam int unsigned V_TOTAL  = V_DISP + V_FP + V_PULSE + V_BP;
  localparam int unsigned HS_START = H_DISP + H_FP;
  localparam int unsigned HS_END   = H_DISP + H_FP + H_PULSE;
  localparam int unsigned VS_START = V_DISP + V_FP;
  localparam int unsigned VS_END   = V_DISP + V_FP + V_PULSE;
  localparam logic        HS_ACT   = 1'(HS_POL);
  localparam logic        VS_ACT   = 1'(VS_POL);

  logic [CNT_W-1:0] hc_q, hc_d;
  logic [CNT_W-1:0] vc_q, vc_d;
  logic [15:0]      frame_q, frame_d;
  logic             h_last, v_last;
  logic             raw_de, raw_hs, raw_vs;

  assign h_last = (32'(hc_q) == H_TOTAL - 1);
  assign v_last = (32'(vc_q) == V_TOTAL - 1);

  // Raster counters and frame counter next-state
  always_comb begin
    hc_d    = hc_q;
    vc_d    = vc_q;
    frame_d = frame_q;
    if (i_en) begin
      if (h_last) begin
        hc_d = '0;
        if (v_last) begin
          vc_d    = '0;
          frame_d = frame_q + 16'd1;
        end else begin
          vc_d = vc_q + CNT_W'(1);
        end
      end else begin
        hc_d = hc_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      hc_q    <= '0;
      vc_q    <= '0;
      frame_q <= '0;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      frame_q <= frame_d;
    end
  end

  assign raw_de = (32'(hc_q) < H_DISP) && (32'(vc_q) < V_DISP);
  assign raw_hs = ((32'(hc_q) >= HS_START) && (32'(hc_q) < HS_END)) ? HS_ACT : ~HS_ACT;
  assign raw_vs = ((32'(vc_q) >= VS_START) && (32'(vc_q) < VS_END)) ? VS_ACT : ~VS_ACT;

  assign o_x         = hc_q;
  assign o_y         = vc_q;
  assign o_active    = raw_de;
  assign o_frame_cnt = frame_q;
  assign o_sof       = i_en && (hc_q == '0) && (vc_q == '0);
  assign o_eol       = i_en && h_last;

`ifdef VGA_RGB_PASS_EN
  logic        rgb_gate;
  logic [23:0] rgb_q;
`endif

  // Sync/DE alignment with the downstream pixel-fetch pipeline
  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign o_de    = raw_de;
      assign o_hsync = raw_hs;
      assign o_vsync = raw_vs;
`ifdef VGA_RGB_PASS_EN
      assign rgb_gate = raw_de;
`endif
    end else begin : g_dly
      localparam int unsigned GATE_IDX = (PIPE_DLY >= 2) ? PIPE_DLY - 2 : 0;
      logic [PIPE_DLY-1:0] de_sr_q;
      logic [PIPE_DLY-1:0] hs_sr_q;
      logic [PIPE_DLY-1:0] vs_sr_q;

      always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
          de_sr_q <= '0;
          hs_sr_q <= {PIPE_DLY{~HS_ACT}};
          vs_sr_q <= {PIPE_DLY{~VS_ACT}};
        end else if (i_en) begin
          de_sr_q <= PIPE_DLY'({de_sr_q, raw_de});
          hs_sr_q <= PIPE_DLY'({hs_sr_q, raw_hs});
          vs_sr_q <= PIPE_DLY'({vs_sr_q, raw_vs});
        end
      end

      assign o_de    = de_sr_q[PIPE_DLY-1];
      assign o_hsync = hs_sr_q[PIPE_DLY-1];
      assign o_vsync = vs_sr_q[PIPE_DLY-1];
`ifdef VGA_RGB_PASS_EN
      // One stage short of o_de so the registered RGB lands on the same tick
      assign rgb_gate = (PIPE_DLY >= 2) ? de_sr_q[GATE_IDX] : raw_de;
`endif
    end
  endgenerate

`ifdef VGA_RGB_PASS_EN
  // Forces black outside the display region
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rgb_q <= '0;
    end else if (i_en) begin
      rgb_q <= rgb_gate ? i_rgb : 24'h0;
    end
  end

  assign o_rgb = rgb_q;
`endif

endmodule
